// File: rtl/safe_entry_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// safe_entry_controller : code-entry sequencer (entry, check, open, program,
//                         lockout) for the digital safe.
// Rev 1.0
// ----------------------------------------------------------------------------
module safe_entry_controller #(
  parameter int                    NUM_DIGITS     = 4,
  parameter int                    MAX_ATTEMPTS   = 3,
  parameter int                    OPEN_CYCLES    = 50000000,
  parameter int                    LOCKOUT_CYCLES = 500000000,
  parameter logic [NUM_DIGITS*4-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                          clk,
  input  logic                          sys_reset_n,
  input  logic                          enter_pulse,
  input  logic                          clear_pulse,
  input  logic                          lock_pulse,
  input  logic                          program_pulse,
  input  logic [3:0]                    current_digit,
  output logic                          enable_digit_select,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_index,
  output logic                          unlocked,
  output logic                          program_mode,
  output logic                          lockout,
  output logic                          error_pulse,
  output logic [3:0]                    attempts_left
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int BW   = NUM_DIGITS * 4;
  localparam int MAXC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] S_ENTRY   = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_PROGRAM = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  logic [2:0]    r_state;
  logic [BW-1:0] r_buf;
  logic [BW-1:0] r_code;
  logic [IW-1:0] r_idx;
  logic [3:0]    r_fail;
  logic [TW-1:0] r_timer;
  logic          r_err;

  logic [BW-1:0] w_buf_wr;
  logic          w_last;
  logic [3:0]    w_fail_inc;

  // Buffer with current_digit dropped into the slot for r_idx (first digit in MS nibble).
  always_comb begin
    w_buf_wr = r_buf;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) w_buf_wr[(NUM_DIGITS-1-k)*4 +: 4] = current_digit;
    end
  end

  assign w_last     = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_fail_inc = r_fail + 4'd1;

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state <= S_ENTRY;
      r_buf   <= '0;
      r_code  <= DEFAULT_CODE;
      r_idx   <= '0;
      r_fail  <= 4'd0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_ENTRY: begin
          if (clear_pulse) begin
            r_buf <= '0;
            r_idx <= '0;
          end else if (enter_pulse) begin
            r_buf <= w_buf_wr;
            if (w_last) begin
              r_idx   <= '0;
              r_state <= S_CHECK;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        S_CHECK: begin
          r_buf <= '0;
          if (r_buf == r_code) begin
            r_state <= S_OPEN;
            r_fail  <= 4'd0;
            r_timer <= '0;
          end else begin
            r_err  <= 1'b1;
            r_fail <= w_fail_inc;
            if (w_fail_inc == 4'(MAX_ATTEMPTS)) begin
              r_state <= S_LOCKOUT;
              r_timer <= '0;
            end else begin
              r_state <= S_ENTRY;
            end
          end
        end
        S_OPEN: begin
          if (lock_pulse) begin
            r_state <= S_ENTRY;
          end else if (program_pulse) begin
            r_state <= S_PROGRAM;
            r_idx   <= '0;
            r_buf   <= '0;
          end else if (r_timer == TW'(OPEN_CYCLES - 1)) begin
            r_state <= S_ENTRY;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_PROGRAM: begin
          if (lock_pulse) begin
            r_state <= S_ENTRY;
            r_buf   <= '0;
            r_idx   <= '0;
          end else if (clear_pulse) begin
            r_buf <= '0;
            r_idx <= '0;
          end else if (enter_pulse) begin
            if (w_last) begin
              r_code  <= w_buf_wr;
              r_buf   <= '0;
              r_idx   <= '0;
              r_state <= S_ENTRY;
            end else begin
              r_buf <= w_buf_wr;
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        S_LOCKOUT: begin
          if (r_timer == TW'(LOCKOUT_CYCLES - 1)) begin
            r_state <= S_ENTRY;
            r_fail  <= 4'd0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_ENTRY;
      endcase
    end
  end

  assign enable_digit_select = (r_state == S_ENTRY) || (r_state == S_PROGRAM);
  assign unlocked            = (r_state == S_OPEN) || (r_state == S_PROGRAM);
  assign program_mode        = (r_state == S_PROGRAM);
  assign lockout             = (r_state == S_LOCKOUT);
  assign error_pulse         = r_err;
  assign digit_index         = r_idx;
  assign attempts_left       = (r_state == S_LOCKOUT) ? 4'd0 : (4'(MAX_ATTEMPTS) - r_fail);

endmodule
`default_nettype wire

// File: tb/tb_safe_entry_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_safe_entry_controller : directed scoreboard bench for safe_entry_controller.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_safe_entry_controller;

  logic       clk = 1'b0;
  logic       sys_reset_n = 1'b0;
  logic       enter_pulse = 1'b0;
  logic       clear_pulse = 1'b0;
  logic       lock_pulse = 1'b0;
  logic       program_pulse = 1'b0;
  logic [3:0] current_digit = 4'd0;
  logic       enable_digit_select;
  logic [1:0] digit_index;
  logic       unlocked;
  logic       program_mode;
  logic       lockout;
  logic       error_pulse;
  logic [3:0] attempts_left;

  safe_entry_controller #(
    .NUM_DIGITS(4), .MAX_ATTEMPTS(3), .OPEN_CYCLES(16), .LOCKOUT_CYCLES(8),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .sys_reset_n(sys_reset_n), .enter_pulse(enter_pulse),
    .clear_pulse(clear_pulse), .lock_pulse(lock_pulse), .program_pulse(program_pulse),
    .current_digit(current_digit), .enable_digit_select(enable_digit_select),
    .digit_index(digit_index), .unlocked(unlocked), .program_mode(program_mode),
    .lockout(lockout), .error_pulse(error_pulse), .attempts_left(attempts_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [1:0] idx;
    logic       unl;
    logic       pm;
    logic       lo;
    logic       err;
    logic [3:0] att;
  } exp_t;

  exp_t q_exp[$];
  int   q_id[$];
  int   step_id = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(logic en, logic [1:0] idx, logic unl, logic pm,
                              logic lo, logic err, logic [3:0] att);
    exp_t x;
    x.en = en; x.idx = idx; x.unl = unl; x.pm = pm; x.lo = lo; x.err = err; x.att = att;
    return x;
  endfunction

  task automatic check(input string nm, input exp_t e);
    exp_t a;
    a = {enable_digit_select, digit_index, unlocked, program_mode, lockout, error_pulse, attempts_left};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got en/idx/unl/pm/lo/err/att=%b want %b", nm, a, e);
    end
  endtask

  // Monitor: one expected snapshot per clock edge that had stimulus queued for it.
  always @(posedge clk) begin
    #1;
    if (q_exp.size() > 0) check($sformatf("step%0d", q_id.pop_front()), q_exp.pop_front());
  end

  task automatic cyc(input logic e, input logic c, input logic l, input logic p,
                     input logic [3:0] d, input exp_t x);
    enter_pulse = e; clear_pulse = c; lock_pulse = l; program_pulse = p; current_digit = d;
    q_exp.push_back(x);
    q_id.push_back(step_id);
    step_id++;
    @(posedge clk);
    #2;
    enter_pulse = 1'b0; clear_pulse = 1'b0; lock_pulse = 1'b0; program_pulse = 1'b0;
    current_digit = 4'd0;
  endtask

  task automatic idle(input exp_t x);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, x);
  endtask

  // Enter a full 4-digit code; in ENTRY the last digit leads to CHECK, in PROGRAM to ENTRY.
  task automatic digits(input logic [15:0] code, input logic [3:0] att, input logic prog);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = code[15-4*i -: 4];
      if (i < 3)     cyc(1'b1, 1'b0, 1'b0, 1'b0, d, mk(1'b1, 2'(i + 1), prog, prog, 1'b0, 1'b0, att));
      else if (prog) cyc(1'b1, 1'b0, 1'b0, 1'b0, d, mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, att));
      else           cyc(1'b1, 1'b0, 1'b0, 1'b0, d, mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, att));
    end
  endtask

  localparam exp_t E_ENTRY = '{en:1'b1, idx:2'd0, unl:1'b0, pm:1'b0, lo:1'b0, err:1'b0, att:4'd3};
  localparam exp_t E_OPEN  = '{en:1'b0, idx:2'd0, unl:1'b1, pm:1'b0, lo:1'b0, err:1'b0, att:4'd3};
  localparam exp_t E_PROG0 = '{en:1'b1, idx:2'd0, unl:1'b1, pm:1'b1, lo:1'b0, err:1'b0, att:4'd3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset_state", E_ENTRY);
    @(negedge clk) sys_reset_n = 1'b1;
    @(posedge clk);
    #2;

    // Correct code then a full-length OPEN window of 16 cycles.
    digits(16'h1234, 4'd3, 1'b0);
    repeat (16) idle(E_OPEN);
    idle(E_ENTRY);

    // Three failures, lockout for 8 cycles with enter presses ignored.
    for (int k = 0; k < 3; k++) begin
      digits(16'h1235, 4'(3 - k), 1'b0);
      if (k < 2) idle(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(2 - k)));
      else       idle(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0));
    end
    for (int k = 0; k < 7; k++)
      cyc(k[0], 1'b0, 1'b0, 1'b0, 4'd1, mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    idle(E_ENTRY);

    // Partial entry, clear wins over simultaneous enter; lock/program ignored in ENTRY.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, mk(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, E_ENTRY);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, E_ENTRY);
    digits(16'h1234, 4'd3, 1'b0);
    idle(E_OPEN);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, E_ENTRY);

    // Reprogram to 5678, old code fails, new code opens.
    digits(16'h1234, 4'd3, 1'b0);
    idle(E_OPEN);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, E_PROG0);
    digits(16'h5678, 4'd3, 1'b1);
    digits(16'h1234, 4'd3, 1'b0);
    idle(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2));
    digits(16'h5678, 4'd2, 1'b0);
    idle(E_OPEN);

    // Program abort after 2 digits keeps the stored code.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, E_PROG0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, mk(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, E_ENTRY);
    digits(16'h5678, 4'd3, 1'b0);
    idle(E_OPEN);
    repeat (5) idle(E_OPEN);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, E_ENTRY);

    // Lock beats program when both arrive in OPEN.
    digits(16'h5678, 4'd3, 1'b0);
    idle(E_OPEN);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, E_ENTRY);

    // Two failures, partial entry, then asynchronous reset between edges.
    digits(16'h1234, 4'd3, 1'b0);
    idle(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2));
    digits(16'h1234, 4'd2, 1'b0);
    idle(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, mk(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1));
    #1 sys_reset_n = 1'b0;
    #1 check("async_reset", E_ENTRY);
    @(negedge clk) sys_reset_n = 1'b1;
    @(posedge clk);
    #2;
    digits(16'h1234, 4'd3, 1'b0);
    idle(E_OPEN);

    for (int w = 0; w < 10 && q_exp.size() > 0; w++) @(posedge clk);
    #3;
    if (q_exp.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
